// File: rtl/uart_pkg.sv
// Shared UART definitions: frame parity mode, receiver states and the
// baud-tick divisor used by both the receiver and the companion transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAITHI
  } rx_state_t;

  // Clocks per sample tick, rounded to nearest.
  function automatic int divisor(input longint fclk, input longint tick_rate);
    return int'((fclk + tick_rate / 2) / tick_rate);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receive-side byte stream: FIFO head fields with a valid/ready pop handshake.
interface uart_rx_os_if #(
  parameter int WDATA = 8
);
  logic [WDATA-1:0] DOUT;
  logic             PERR;
  logic             FERR;
  logic             VALID;
  logic             READY;

  modport master (output DOUT, PERR, FERR, VALID, input READY);
  modport slave  (input DOUT, PERR, FERR, VALID, output READY);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted
// only when a pop happens on the same edge.
module uart_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are live, so this stays a plain RAM.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, 3-sample majority vote per
// bit, optional parity, framing/break detection and an FWFT receive FIFO.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int BAUDS      = 115200,
  parameter int FCLK       = 12000000,
  parameter int WDATA      = 8,
  parameter int WSTOP      = 1,
  parameter int PARITY     = 0,
  parameter int OVERSAMPLE = 16,
  parameter int DEPTH      = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         RXD,
  uart_rx_os_if.master rx,
  output logic         OVERRUN,
  output logic         BREAK
);
  localparam int      NDIV  = divisor(longint'(FCLK), longint'(BAUDS) * OVERSAMPLE);
  localparam int      DW    = $clog2(NDIV + 1);
  localparam int      OW    = $clog2(OVERSAMPLE);
  localparam int      BW    = $clog2(WDATA + 1);
  localparam parity_t PMODE = parity_t'(PARITY);
  localparam logic [OW-1:0] V0      = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] V1      = OW'(OVERSAMPLE / 2);
  localparam logic [OW-1:0] V2      = OW'(OVERSAMPLE / 2 + 1);
  localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);

  if (NDIV < 1 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_cfg
    $error("uart_rx_os: invalid divisor or oversample setting");
  end

  rx_state_t        state, state_next;
  logic             rxd_s1, rxd_s2, rxd_s3;
  logic [DW-1:0]    div_cnt;
  logic [OW-1:0]    os_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WDATA-1:0] shreg;
  logic             samp0, samp1, par_bit, perr, ferr;
  logic             start_fall, tick, vote_now, voted, last_data, last_stop, exp_par;
  logic             push, brk, frame_ferr, pop, fifo_full, fifo_empty;
  logic [WDATA+1:0] head;

  assign start_fall = rxd_s3 && !rxd_s2;
  assign tick       = (div_cnt == DW'(NDIV - 1));
  assign vote_now   = tick && (os_cnt == V2);
  assign voted      = (samp0 & samp1) | (samp0 & rxd_s2) | (samp1 & rxd_s2);
  assign last_data  = (bit_cnt == BW'(WDATA - 1));
  assign last_stop  = (bit_cnt == BW'(WSTOP - 1));
  assign exp_par    = (^shreg) ^ (PMODE == PAR_ODD);

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    brk        = 1'b0;
    frame_ferr = ferr;
    unique case (state)
      ST_IDLE:   if (start_fall) state_next = ST_START;
      ST_START:  if (vote_now) state_next = voted ? ST_IDLE : ST_DATA;
      ST_DATA:   if (vote_now && last_data)
                   state_next = (PMODE == PAR_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY: if (vote_now) state_next = ST_STOP;
      ST_STOP: begin
        if (vote_now) begin
          frame_ferr = ferr | ~voted;
          if (last_stop) begin
            push       = 1'b1;
            brk        = frame_ferr && (shreg == '0) && !par_bit;
            state_next = frame_ferr ? ST_WAITHI : ST_IDLE;
          end
        end
      end
      // A full bit time of continuous high is needed before re-arming.
      ST_WAITHI: if (tick && rxd_s2 && os_cnt == OS_LAST) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rxd_s1  <= 1'b1;
      rxd_s2  <= 1'b1;
      rxd_s3  <= 1'b1;
      div_cnt <= '0;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      samp0   <= 1'b1;
      samp1   <= 1'b1;
      par_bit <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      rxd_s1  <= RXD;
      rxd_s2  <= rxd_s1;
      rxd_s3  <= rxd_s2;
      div_cnt <= (tick || (state == ST_IDLE && start_fall)) ? '0 : div_cnt + 1'b1;
      if (tick && os_cnt == V0) samp0 <= rxd_s2;
      if (tick && os_cnt == V1) samp1 <= rxd_s2;

      if (state == ST_IDLE) begin
        os_cnt  <= '0;
        bit_cnt <= '0;
        par_bit <= 1'b0;
        perr    <= 1'b0;
        ferr    <= 1'b0;
      end else if ((state != ST_WAITHI && state_next == ST_WAITHI) ||
                   (state == ST_WAITHI && !rxd_s2)) begin
        os_cnt <= '0;
      end else if (tick) begin
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
      end

      if (vote_now) begin
        unique case (state)
          ST_DATA: begin
            shreg   <= {voted, shreg[WDATA-1:1]};
            bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
          end
          ST_PARITY: begin
            par_bit <= voted;
            perr    <= (voted != exp_par);
          end
          ST_STOP: begin
            ferr    <= frame_ferr;
            bit_cnt <= bit_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign pop = !fifo_empty && rx.READY;

  uart_fifo #(.WIDTH(WDATA + 2), .DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .wdata ({frame_ferr, perr, shreg}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head fields are forced to zero while empty so stale RAM never shows.
  assign rx.VALID = !fifo_empty;
  assign rx.DOUT  = fifo_empty ? '0 : head[WDATA-1:0];
  assign rx.PERR  = !fifo_empty && head[WDATA];
  assign rx.FERR  = !fifo_empty && head[WDATA+1];
  assign BREAK    = brk;

  always_ff @(posedge CLK) begin
    if (RST)                             OVERRUN <= 1'b0;
    else if (push && fifo_full && !pop)  OVERRUN <= 1'b1;
    else if (pop)                        OVERRUN <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Randomised scoreboard bench: an 8N1 and an 8E1 receiver at 32 clk per bit,
// checked against a frame-level model of the expected FIFO contents.
module tb_uart_rx_os;
  localparam int CPB   = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd0 = 1'b1, rxd1 = 1'b1;
  logic ready0 = 1'b0, ready1 = 1'b1;
  logic ovr0, ovr1, brk0, brk1;
  bit   rand_on = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int brk_seen0 = 0, brk_seen1 = 0;
  int exp_brk0 = 0, exp_brk1 = 0;
  int exp_ovr0 = 0;
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];

  always #5 clk = ~clk;

  uart_rx_os_if #(.WDATA(8)) if0 ();
  uart_rx_os_if #(.WDATA(8)) if1 ();
  assign if0.READY = ready0;
  assign if1.READY = ready1;

  uart_rx_os #(.BAUDS(100000), .FCLK(3200000), .WDATA(8), .WSTOP(1), .PARITY(0),
               .OVERSAMPLE(16), .DEPTH(DEPTH)) dut0 (
    .CLK(clk), .RST(rst), .RXD(rxd0), .rx(if0), .OVERRUN(ovr0), .BREAK(brk0));

  uart_rx_os #(.BAUDS(100000), .FCLK(3200000), .WDATA(8), .WSTOP(1), .PARITY(2),
               .OVERSAMPLE(16), .DEPTH(DEPTH)) dut1 (
    .CLK(clk), .RST(rst), .RXD(rxd1), .rx(if1), .OVERRUN(ovr1), .BREAK(brk1));

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic drive_bit(input int i, input logic v, input int clks);
    if (i == 0) rxd0 = v;
    else        rxd1 = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  // Frame model: parity bit is even parity of the data (optionally flipped),
  // PERR only matters when the line uses parity, FERR when the stop bit is 0.
  task automatic send_frame(input int i, input logic [7:0] d, input bit par_flip,
                            input bit stop_zero);
    logic pb, perr, ferr;
    bit   has_par;
    has_par = (i == 1);
    pb      = (^d) ^ par_flip;
    perr    = has_par && par_flip;
    ferr    = stop_zero;
    if (i == 0) begin
      if (exp_q0.size() < DEPTH) exp_q0.push_back({ferr, perr, d});
      else                       exp_ovr0 = 1;
      if (ferr && d == 8'h00) exp_brk0++;
    end else begin
      exp_q1.push_back({ferr, perr, d});
      if (ferr && d == 8'h00 && pb == 1'b0) exp_brk1++;
    end
    drive_bit(i, 1'b0, CPB);
    for (int k = 0; k < 8; k++) drive_bit(i, d[k], CPB);
    if (has_par) drive_bit(i, pb, CPB);
    drive_bit(i, ~stop_zero, CPB);
    drive_bit(i, 1'b1, stop_zero ? 3 * CPB : CPB);
  endtask

  always @(negedge clk) begin : mon0
    logic [9:0] e;
    if (brk0) brk_seen0++;
    if (if0.VALID && ready0) begin
      check("pop0_expected", int'(exp_q0.size() != 0), 1);
      if (exp_q0.size() != 0) begin
        e = exp_q0.pop_front();
        check("pop0_entry", {if0.FERR, if0.PERR, if0.DOUT}, e);
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [9:0] e;
    if (brk1) brk_seen1++;
    if (if1.VALID && ready1) begin
      check("pop1_expected", int'(exp_q1.size() != 0), 1);
      if (exp_q1.size() != 0) begin
        e = exp_q1.pop_front();
        check("pop1_entry", {if1.FERR, if1.PERR, if1.DOUT}, e);
      end
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within the cycle budget");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid0", if0.VALID, 0);
    check("rst_head0", {if0.FERR, if0.PERR, if0.DOUT}, 0);
    check("rst_overrun0", ovr0, 0);
    check("rst_break0", brk0, 0);
    check("rst_valid1", if1.VALID, 0);
    check("rst_overrun1", ovr1, 0);
    @(posedge clk); #1;

    // 8N1 0xA5 with VALID latency measured from the start edge.
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0);
      begin
        n = 0;
        while (!if0.VALID && n < 400) begin
          @(negedge clk);
          n++;
        end
        check("valid_latency_in_300_316", int'(n >= 300 && n <= 316), 1);
      end
    join
    @(posedge clk); #1 ready0 = 1'b1;
    repeat (4) @(posedge clk); #1;

    // 8E1 0x01 sent with parity bit 0.
    send_frame(1, 8'h01, 1'b1, 1'b0);

    // Short glitch must not produce a frame.
    ready0 = 1'b0;
    drive_bit(0, 1'b0, 6);
    drive_bit(0, 1'b1, 400);
    check("glitch_no_valid", if0.VALID, 0);
    ready0 = 1'b1;
    send_frame(0, 8'h5A, 1'b0, 1'b0);

    // Break: line low for 12 bit times.
    exp_q0.push_back({1'b1, 1'b0, 8'h00});
    exp_brk0++;
    drive_bit(0, 1'b0, 12 * CPB);
    drive_bit(0, 1'b1, 3 * CPB);
    check("break_pulses0", brk_seen0, exp_brk0);

    // Overrun: five frames into a four-entry FIFO.
    ready0 = 1'b0;
    for (int k = 0; k < 5; k++) send_frame(0, 8'(8'h10 + k), 1'b0, 1'b0);
    check("overrun_set", ovr0, exp_ovr0);
    check("fifo_held_valid", if0.VALID, 1);
    ready0 = 1'b1;
    @(posedge clk); #1 ready0 = 1'b0;
    exp_ovr0 = 0;
    @(negedge clk);
    check("overrun_clear_after_pop", ovr0, exp_ovr0);
    @(posedge clk); #1 ready0 = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("overrun_drained", exp_q0.size(), 0);

    // Reset during data bit 3 aborts the frame.
    ready0 = 1'b0;
    drive_bit(0, 1'b0, CPB);
    drive_bit(0, 1'b1, CPB);
    drive_bit(0, 1'b0, CPB);
    drive_bit(0, 1'b1, CPB);
    drive_bit(0, 1'b0, CPB / 2);
    rst  = 1'b1;
    rxd0 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_abort_valid", if0.VALID, 0);
    repeat (400) @(posedge clk); #1;
    check("rst_abort_no_entry", if0.VALID, 0);
    ready0 = 1'b1;
    send_frame(0, 8'h3C, 1'b0, 1'b0);

    // Random traffic on both lines, random back-pressure on the 8E1 side.
    rand_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 10; k++)
          send_frame(0, 8'($urandom), 1'b0, ($urandom_range(0, 9) == 0));
      end
      begin
        for (int k = 0; k < 10; k++)
          send_frame(1, 8'($urandom), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 7) == 0));
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1 ready1 = ($urandom_range(0, 3) != 0);
        end
        ready1 = 1'b1;
      end
    join

    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("final_queue0_empty", exp_q0.size(), 0);
    check("final_queue1_empty", exp_q1.size(), 0);
    check("final_valid0", if0.VALID, 0);
    check("final_valid1", if1.VALID, 0);
    check("final_break_count0", brk_seen0, exp_brk0);
    check("final_break_count1", brk_seen1, exp_brk1);
    check("final_overrun1", ovr1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
